// File: rtl/csr_commit_sequencer.sv
`default_nettype none
// ============================================================================
// csr_commit_sequencer: captures one CSR request at commit, issues it to the
// CSR file, waits with replay/timeout handling and returns read data to WB.
// Revision: 1.0
// ============================================================================
module csr_commit_sequencer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_REPLAY     = 3
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        flush_i,
  input  logic        csr_ena_i,
  input  logic [2:0]  csr_cmd_i,
  input  logic [11:0] csr_addr_i,
  input  logic [63:0] csr_wdata_i,
  input  logic [4:0]  csr_rd_i,
  input  logic        csr_rd_we_i,
  output logic        csr_req_valid_o,
  output logic [2:0]  csr_cmd_o,
  output logic [11:0] csr_addr_o,
  output logic [63:0] csr_wdata_o,
  input  logic        csr_resp_valid_i,
  input  logic [63:0] csr_rdata_i,
  input  logic        csr_xcpt_i,
  input  logic        csr_replay_i,
  output logic        commit_stall_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [63:0] wb_data_o,
  output logic        xcpt_o,
  output logic        timeout_o,
  output logic        busy_o
);

  localparam int                WAIT_W       = $clog2(TIMEOUT_CYCLES);
  localparam int                REP_W        = $clog2(MAX_REPLAY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST    = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_MAX      = REP_W'(MAX_REPLAY);
  localparam logic [2:0]        CSR_CMD_NOPE = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         cmd_q, cmd_d;
  logic [11:0]        addr_q, addr_d;
  logic [63:0]        wdata_q, wdata_d;
  logic [4:0]         rd_q, rd_d;
  logic               rd_we_q, rd_we_d;
  logic [63:0]        rdata_q, rdata_d;
  logic [REP_W-1:0]   replay_cnt_q, replay_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               err_q, err_d;
  logic               tmo_q, tmo_d;
  logic               req_q, req_d;
  logic               wb_q, wb_d;
  logic               xcpt_q, xcpt_d;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    rd_we_d      = rd_we_q;
    rdata_d      = rdata_q;
    replay_cnt_d = replay_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    tmo_d        = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (csr_ena_i && csr_cmd_i != CSR_CMD_NOPE) begin
          cmd_d        = csr_cmd_i;
          addr_d       = csr_addr_i;
          wdata_d      = csr_wdata_i;
          rd_d         = csr_rd_i;
          rd_we_d      = csr_rd_we_i;
          replay_cnt_d = '0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        // A response always wins over a timeout hitting in the same cycle.
        if (csr_resp_valid_i) begin
          if (csr_xcpt_i) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (csr_replay_i) begin
            if (replay_cnt_q < REP_MAX) begin
              replay_cnt_d = replay_cnt_q + 1'b1;
              state_d      = ST_ISSUE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          end else begin
            rdata_d = csr_rdata_i;
            state_d = ST_DONE;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (flush_i) state_d = ST_IDLE;

    // Payload is wiped on every return to IDLE so the outputs read 0 there.
    if (state_d == ST_IDLE) begin
      cmd_d        = '0;
      addr_d       = '0;
      wdata_d      = '0;
      rd_d         = '0;
      rd_we_d      = 1'b0;
      rdata_d      = '0;
      replay_cnt_d = '0;
      wait_cnt_d   = '0;
      err_d        = 1'b0;
      tmo_d        = 1'b0;
    end

    req_d  = (state_d == ST_ISSUE);
    wb_d   = (state_d == ST_DONE) && !err_d && rd_we_d && (rd_d != 5'd0);
    xcpt_d = (state_d == ST_DONE) && err_d;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      rd_we_q      <= 1'b0;
      rdata_q      <= '0;
      replay_cnt_q <= '0;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
      tmo_q        <= 1'b0;
      req_q        <= 1'b0;
      wb_q         <= 1'b0;
      xcpt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      rd_we_q      <= rd_we_d;
      rdata_q      <= rdata_d;
      replay_cnt_q <= replay_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
      tmo_q        <= tmo_d;
      req_q        <= req_d;
      wb_q         <= wb_d;
      xcpt_q       <= xcpt_d;
    end
  end

  // A flush kills any strobe that would otherwise leave in the same cycle.
  assign csr_req_valid_o = req_q && !flush_i;
  assign wb_valid_o      = wb_q && !flush_i;
  assign xcpt_o          = xcpt_q && !flush_i;
  assign timeout_o       = xcpt_o && tmo_q;
  assign csr_cmd_o       = cmd_q;
  assign csr_addr_o      = addr_q;
  assign csr_wdata_o     = wdata_q;
  assign wb_rd_o         = rd_q;
  assign wb_data_o       = rdata_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign commit_stall_o  = ((state_q == ST_IDLE) && csr_ena_i && !flush_i) ||
                           (state_q == ST_ISSUE) || (state_q == ST_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_csr_commit_sequencer.sv
`default_nettype none
// tb_csr_commit_sequencer: directed transactions; expected strobes are queued
// by the stimulus and popped by an independent negedge monitor.
module tb_csr_commit_sequencer;

  localparam int TIMEOUT_CYCLES = 8;
  localparam int MAX_REPLAY     = 3;
  localparam int EV_REQ = 0;
  localparam int EV_WB  = 1;
  localparam int EV_X   = 2;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        csr_ena_i = 1'b0;
  logic [2:0]  csr_cmd_i = '0;
  logic [11:0] csr_addr_i = '0;
  logic [63:0] csr_wdata_i = '0;
  logic [4:0]  csr_rd_i = '0;
  logic        csr_rd_we_i = 1'b0;
  logic        csr_resp_valid_i = 1'b0;
  logic [63:0] csr_rdata_i = '0;
  logic        csr_xcpt_i = 1'b0;
  logic        csr_replay_i = 1'b0;
  logic        csr_req_valid_o;
  logic [2:0]  csr_cmd_o;
  logic [11:0] csr_addr_o;
  logic [63:0] csr_wdata_o;
  logic        commit_stall_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [63:0] wb_data_o;
  logic        xcpt_o;
  logic        timeout_o;
  logic        busy_o;

  csr_commit_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .MAX_REPLAY    (MAX_REPLAY)
  ) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .flush_i         (flush_i),
    .csr_ena_i       (csr_ena_i),
    .csr_cmd_i       (csr_cmd_i),
    .csr_addr_i      (csr_addr_i),
    .csr_wdata_i     (csr_wdata_i),
    .csr_rd_i        (csr_rd_i),
    .csr_rd_we_i     (csr_rd_we_i),
    .csr_req_valid_o (csr_req_valid_o),
    .csr_cmd_o       (csr_cmd_o),
    .csr_addr_o      (csr_addr_o),
    .csr_wdata_o     (csr_wdata_o),
    .csr_resp_valid_i(csr_resp_valid_i),
    .csr_rdata_i     (csr_rdata_i),
    .csr_xcpt_i      (csr_xcpt_i),
    .csr_replay_i    (csr_replay_i),
    .commit_stall_o  (commit_stall_o),
    .wb_valid_o      (wb_valid_o),
    .wb_rd_o         (wb_rd_o),
    .wb_data_o       (wb_data_o),
    .xcpt_o          (xcpt_o),
    .timeout_o       (timeout_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          cyc;
    logic [2:0]  cmd;
    logic [11:0] addr;
    logic [63:0] data;
    logic [4:0]  rd;
    logic        tmo;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_req(input int c, input logic [2:0] cmd, input logic [11:0] a, input logic [63:0] wd);
    ev_t e;
    e.kind = EV_REQ; e.cyc = c; e.cmd = cmd; e.addr = a; e.data = wd; e.rd = '0; e.tmo = 1'b0;
    q.push_back(e);
  endtask

  task automatic exp_wb(input int c, input logic [4:0] rd, input logic [63:0] d);
    ev_t e;
    e.kind = EV_WB; e.cyc = c; e.cmd = '0; e.addr = '0; e.data = d; e.rd = rd; e.tmo = 1'b0;
    q.push_back(e);
  endtask

  task automatic exp_x(input int c, input logic tmo);
    ev_t e;
    e.kind = EV_X; e.cyc = c; e.cmd = '0; e.addr = '0; e.data = '0; e.rd = '0; e.tmo = tmo;
    q.push_back(e);
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk_i) begin
    ev_t e;
    int  k;
    if (rstn_i && (csr_req_valid_o || wb_valid_o || xcpt_o)) begin
      k = csr_req_valid_o ? EV_REQ : (wb_valid_o ? EV_WB : EV_X);
      if (wb_valid_o && xcpt_o) chk("wb_xcpt_exclusive", 64'(xcpt_o), 64'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual_kind=%0d required=none (cycle %0d)", k, cyc);
      end else begin
        e = q.pop_front();
        chk("event_kind", 64'(k), 64'(e.kind));
        chk("event_cycle", 64'(cyc), 64'(e.cyc));
        if (e.kind == EV_REQ) begin
          chk("req_cmd", 64'(csr_cmd_o), 64'(e.cmd));
          chk("req_addr", 64'(csr_addr_o), 64'(e.addr));
          chk("req_wdata", csr_wdata_o, e.data);
        end else if (e.kind == EV_WB) begin
          chk("wb_rd", 64'(wb_rd_o), 64'(e.rd));
          chk("wb_data", wb_data_o, e.data);
        end else begin
          chk("xcpt_timeout", 64'(timeout_o), 64'(e.tmo));
        end
      end
    end
  end

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  // Drives the accept cycle, returns positioned in the ISSUE cycle.
  task automatic accept(input logic [2:0] cmd, input logic [11:0] a, input logic [63:0] wd,
                        input logic [4:0] rd, input logic we);
    csr_ena_i = 1'b1; csr_cmd_i = cmd; csr_addr_i = a; csr_wdata_i = wd;
    csr_rd_i = rd; csr_rd_we_i = we;
    #1;
    chk("stall_on_accept", 64'(commit_stall_o), 64'd1);
    next();
    csr_ena_i = 1'b0; csr_cmd_i = '0; csr_addr_i = '0; csr_wdata_i = '0;
    csr_rd_i = '0; csr_rd_we_i = 1'b0;
  endtask

  task automatic respond(input logic xc, input logic rep, input logic [63:0] rdata);
    csr_resp_valid_i = 1'b1; csr_xcpt_i = xc; csr_replay_i = rep; csr_rdata_i = rdata;
    next();
    csr_resp_valid_i = 1'b0; csr_xcpt_i = 1'b0; csr_replay_i = 1'b0; csr_rdata_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #3;
    chk("rst_req_valid", 64'(csr_req_valid_o), 64'd0);
    chk("rst_stall", 64'(commit_stall_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_xcpt", 64'(xcpt_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_cmd", 64'(csr_cmd_o), 64'd0);
    chk("rst_addr", 64'(csr_addr_o), 64'd0);
    chk("rst_wb_data", wb_data_o, 64'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    next();

    // Basic CSRRW
    t = cyc;
    exp_req(t + 1, 3'd3, 12'h340, 64'hA5);
    exp_wb(t + 3, 5'd5, 64'h1234);
    accept(3'd3, 12'h340, 64'hA5, 5'd5, 1'b1);
    chk("stall_issue", 64'(commit_stall_o), 64'd1);
    next();
    chk("stall_wait", 64'(commit_stall_o), 64'd1);
    respond(1'b0, 1'b0, 64'h1234);
    chk("stall_done", 64'(commit_stall_o), 64'd0);
    chk("busy_done", 64'(busy_o), 64'd1);
    next();
    chk("busy_idle", 64'(busy_o), 64'd0);
    chk("addr_idle", 64'(csr_addr_o), 64'd0);
    chk("wb_data_idle", wb_data_o, 64'd0);

    // Write to x0: no write-back
    t = cyc;
    exp_req(t + 1, 3'd3, 12'h340, 64'hA5);
    accept(3'd3, 12'h340, 64'hA5, 5'd0, 1'b1);
    next();
    respond(1'b0, 1'b0, 64'h1234);
    chk("x0_stall_done", 64'(commit_stall_o), 64'd0);
    chk("x0_no_wb", 64'(wb_valid_o), 64'd0);
    next();

    // Three replays, then data
    t = cyc;
    for (int i = 0; i < 4; i++) exp_req(t + 1 + 2 * i, 3'd2, 12'h300, 64'h0F);
    exp_wb(t + 9, 5'd7, 64'hBEEF);
    accept(3'd2, 12'h300, 64'h0F, 5'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      next();
      respond(1'b0, 1'b1, 64'h0);
    end
    next();
    respond(1'b0, 1'b0, 64'hBEEF);
    next();

    // Four replays: replay exhaustion exception
    t = cyc;
    for (int i = 0; i < 4; i++) exp_req(t + 1 + 2 * i, 3'd2, 12'h300, 64'h0F);
    exp_x(t + 9, 1'b0);
    accept(3'd2, 12'h300, 64'h0F, 5'd7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      next();
      respond(1'b0, 1'b1, 64'h0);
    end
    chk("replay_x_nowb", 64'(wb_valid_o), 64'd0);
    next();

    // Timeout: no response at all
    t = cyc;
    exp_req(t + 1, 3'd1, 12'hB00, 64'h1);
    exp_x(t + 10, 1'b1);
    accept(3'd1, 12'hB00, 64'h1, 5'd2, 1'b1);
    for (int i = 0; i < 9; i++) next();
    chk("tmo_stall_done", 64'(commit_stall_o), 64'd0);
    next();
    chk("tmo_idle", 64'(busy_o), 64'd0);

    // Response on the last WAIT cycle beats the timeout
    t = cyc;
    exp_req(t + 1, 3'd1, 12'hB01, 64'h2);
    exp_wb(t + 10, 5'd6, 64'h600D);
    accept(3'd1, 12'hB01, 64'h2, 5'd6, 1'b1);
    for (int i = 0; i < 8; i++) next();
    respond(1'b0, 1'b0, 64'h600D);
    chk("edge_not_timeout", 64'(timeout_o), 64'd0);
    next();

    // Access fault with replay also set: exception wins, no reissue
    t = cyc;
    exp_req(t + 1, 3'd1, 12'h7C0, 64'h3);
    exp_x(t + 3, 1'b0);
    accept(3'd1, 12'h7C0, 64'h3, 5'd3, 1'b1);
    next();
    respond(1'b1, 1'b1, 64'h55);
    next();
    next();

    // Response in the ISSUE cycle is not sampled
    t = cyc;
    exp_req(t + 1, 3'd2, 12'h305, 64'h9);
    exp_wb(t + 3, 5'd9, 64'hCAFE);
    accept(3'd2, 12'h305, 64'h9, 5'd9, 1'b1);
    respond(1'b0, 1'b0, 64'hDEAD);
    respond(1'b0, 1'b0, 64'hCAFE);
    next();

    // Flush in WAIT, stale response, then a fresh request
    t = cyc;
    exp_req(t + 1, 3'd1, 12'h300, 64'h4);
    accept(3'd1, 12'h300, 64'h4, 5'd4, 1'b1);
    next();
    flush_i = 1'b1;
    next();
    flush_i = 1'b0;
    csr_resp_valid_i = 1'b1; csr_rdata_i = 64'h77;
    #1;
    chk("flush_idle", 64'(busy_o), 64'd0);
    chk("flush_no_stall", 64'(commit_stall_o), 64'd0);
    next();
    csr_resp_valid_i = 1'b0; csr_rdata_i = '0;
    chk("stale_ignored", 64'(busy_o), 64'd0);
    t = cyc;
    exp_req(t + 1, 3'd3, 12'h341, 64'h8);
    exp_wb(t + 3, 5'd11, 64'h4242);
    accept(3'd3, 12'h341, 64'h8, 5'd11, 1'b1);
    next();
    respond(1'b0, 1'b0, 64'h4242);
    next();

    // Asynchronous reset in the ISSUE cycle
    accept(3'd3, 12'h342, 64'hFF, 5'd12, 1'b1);
    chk("pre_rst_req", 64'(csr_req_valid_o), 64'd1);
    #1;
    rstn_i = 1'b0;
    #1;
    chk("arst_req_valid", 64'(csr_req_valid_o), 64'd0);
    chk("arst_stall", 64'(commit_stall_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_addr", 64'(csr_addr_o), 64'd0);
    chk("arst_wdata", csr_wdata_o, 64'd0);
    chk("arst_cmd", 64'(csr_cmd_o), 64'd0);
    next();
    rstn_i = 1'b1;
    next();
    next();
    chk("post_rst_idle", 64'(busy_o), 64'd0);

    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
